// File: rtl/maze_player_ctrl.sv
// Player position controller for the 16x16 maze.
// Accepts single-cycle direction pulses, fetches the target cell from the maze
// BRAM to test for a wall, and commits the move or reports a bump.
// Tracks the move count and whether the player is on the goal cell.
module maze_player_ctrl #(
  parameter int unsigned START_X    = 1,
  parameter int unsigned START_Y    = 1,
  parameter int unsigned GOAL_X     = 14,
  parameter int unsigned GOAL_Y     = 14,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned CNT_W      = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             btn_left,
  input  logic             btn_right,
  input  logic [8:0]       bram_rd_data,
  output logic [7:0]       bram_rd_addr,
  output logic [3:0]       player_x,
  output logic [3:0]       player_y,
  output logic [CNT_W-1:0] move_count,
  output logic             bump,
  output logic             at_goal,
  output logic             busy
);

  localparam int unsigned WAIT_W = 2;
  localparam logic [3:0] START_X4 = 4'(START_X);
  localparam logic [3:0] START_Y4 = 4'(START_Y);
  localparam logic [3:0] GOAL_X4  = 4'(GOAL_X);
  localparam logic [3:0] GOAL_Y4  = 4'(GOAL_Y);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RD_LATENCY - 1);
  localparam logic START_AT_GOAL = (START_X4 == GOAL_X4) && (START_Y4 == GOAL_Y4);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READY,
    S_FETCH,
    S_CHECK,
    S_WON
  } state_t;

  state_t            r_state;
  logic [3:0]        r_x;
  logic [3:0]        r_y;
  logic [3:0]        r_tgt_x;
  logic [3:0]        r_tgt_y;
  logic [7:0]        r_addr;
  logic [CNT_W-1:0]  r_cnt;
  logic [WAIT_W-1:0] r_wait;
  logic              r_bump;
  logic              r_at_goal;
  logic              r_busy;

  logic       w_req;
  logic       w_off_grid;
  logic [3:0] w_tgt_x;
  logic [3:0] w_tgt_y;
  logic       w_wall;
  logic [3:0] w_new_x;
  logic [3:0] w_new_y;
  logic       w_new_at_goal;
  logic       w_unused_data;

  // Only the wall bit of the BRAM word carries meaning here.
  assign w_unused_data = ^bram_rd_data[8:1];
  assign w_wall        = bram_rd_data[0];

  // Pick one direction by priority (up > down > left > right) and form its target.
  always_comb begin
    w_req      = btn_up | btn_down | btn_left | btn_right;
    w_off_grid = 1'b0;
    w_tgt_x    = r_x;
    w_tgt_y    = r_y;
    if (btn_up) begin
      w_off_grid = (r_y == 4'd0);
      w_tgt_y    = r_y - 4'd1;
    end else if (btn_down) begin
      w_off_grid = (r_y == 4'd15);
      w_tgt_y    = r_y + 4'd1;
    end else if (btn_left) begin
      w_off_grid = (r_x == 4'd0);
      w_tgt_x    = r_x - 4'd1;
    end else if (btn_right) begin
      w_off_grid = (r_x == 4'd15);
      w_tgt_x    = r_x + 4'd1;
    end
  end

  // Position after the wall check completes, and whether it lands on the goal.
  always_comb begin
    w_new_x       = w_wall ? r_x : r_tgt_x;
    w_new_y       = w_wall ? r_y : r_tgt_y;
    w_new_at_goal = (w_new_x == GOAL_X4) && (w_new_y == GOAL_Y4);
  end

  // Movement FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_x       <= START_X4;
      r_y       <= START_Y4;
      r_tgt_x   <= 4'd0;
      r_tgt_y   <= 4'd0;
      r_addr    <= 8'd0;
      r_cnt     <= '0;
      r_wait    <= '0;
      r_bump    <= 1'b0;
      r_at_goal <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_bump <= 1'b0;
      if (start) begin
        // Any in-flight fetch is abandoned; its data is never sampled.
        r_state   <= START_AT_GOAL ? S_WON : S_READY;
        r_x       <= START_X4;
        r_y       <= START_Y4;
        r_cnt     <= '0;
        r_wait    <= '0;
        r_busy    <= 1'b0;
        r_at_goal <= START_AT_GOAL;
      end else begin
        case (r_state)
          S_READY: begin
            if (w_req) begin
              if (w_off_grid) begin
                r_bump <= 1'b1;
              end else begin
                r_tgt_x <= w_tgt_x;
                r_tgt_y <= w_tgt_y;
                r_addr  <= {w_tgt_y, w_tgt_x};
                r_wait  <= '0;
                r_busy  <= 1'b1;
                r_state <= S_FETCH;
              end
            end
          end
          S_FETCH: begin
            if (r_wait == WAIT_LAST) begin
              r_state <= S_CHECK;
            end else begin
              r_wait <= r_wait + WAIT_W'(1);
            end
          end
          S_CHECK: begin
            if (w_wall) begin
              r_bump <= 1'b1;
            end else begin
              r_x <= r_tgt_x;
              r_y <= r_tgt_y;
              if (r_cnt != '1) begin
                r_cnt <= r_cnt + CNT_W'(1);
              end
            end
            r_at_goal <= w_new_at_goal;
            r_busy    <= 1'b0;
            r_state   <= w_new_at_goal ? S_WON : S_READY;
          end
          S_IDLE, S_WON: begin
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bram_rd_addr = r_addr;
  assign player_x     = r_x;
  assign player_y     = r_y;
  assign move_count   = r_cnt;
  assign bump         = r_bump;
  assign at_goal      = r_at_goal;
  assign busy         = r_busy;

endmodule

// File: doc/maze_player_ctrl.md
Name: maze_player_ctrl

Overview:
Sits directly downstream of the maze generator. It consumes the 16x16 maze stored in the shared maze BRAM through that BRAM's read port. It tracks the player cell, takes debounced single-cycle direction pulses, and fetches each target cell from BRAM to check for a wall before committing a move. It reports position, move count, wall bumps and goal arrival to the renderer and game FSM.

Parameters:
START_X, 1, player column loaded on start (0..15)
START_Y, 1, player row loaded on start (0..15)
GOAL_X, 14, goal column
GOAL_Y, 14, goal row
RD_LATENCY, 1, BRAM read latency in cycles (1..3)
CNT_W, 10, move counter width

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
start  in  1  pulse: load start position, clear counters; driven from the generator's done rising edge
btn_up  in  1  single-cycle direction pulse (y-1)
btn_down  in  1  single-cycle direction pulse (y+1)
btn_left  in  1  single-cycle direction pulse (x-1)
btn_right  in  1  single-cycle direction pulse (x+1)
bram_rd_data  in  9  maze BRAM read data; bit0 = 1 wall, 0 path; bits 8:1 ignored
bram_rd_addr  out  8  maze BRAM read address = {y[3:0], x[3:0]} (row-major, row 0 first)
player_x  out  4  current column
player_y  out  4  current row
move_count  out  CNT_W  committed moves since start, saturating
bump  out  1  one-cycle pulse on a rejected move
at_goal  out  1  high while player is on (GOAL_X, GOAL_Y)
busy  out  1  high while a move check is in flight

Behaviour:
- Reset (reset==0 at a clk edge) takes priority over everything, including mid-fetch:
  - state IDLE; player_x=START_X, player_y=START_Y.
  - move_count=0, bump=0, at_goal=0, busy=0, bram_rd_addr=0.
- States: IDLE, READY, FETCH, CHECK, WON.
- IDLE:
  - Buttons ignored.
  - start -> READY; loads START position; clears move_count.
  - at_goal is evaluated at load, so a start position equal to the goal goes straight to WON.
- start in any non-IDLE state behaves identically: aborts any in-flight fetch and discards its result.
- READY:
  - Sample buttons only when exactly one state edge sees them.
  - Priority when several are high in the same cycle: up > down > left > right; the others are dropped.
  - Target off-grid (up at y=0, down at y=15, left at x=0, right at x=15): no BRAM read, bump=1 next cycle, stay READY.
  - Otherwise: register target into tgt_x/tgt_y, set bram_rd_addr={tgt_y,tgt_x}, go to FETCH, busy=1.
- FETCH:
  - Hold bram_rd_addr for RD_LATENCY cycles using a wait counter, then go to CHECK.
  - Buttons arriving during FETCH/CHECK are ignored, not queued.
- CHECK:
  - Sample bram_rd_data[0].
  - 0: player_x/y <= tgt_x/y; move_count += 1, saturating at all-ones.
  - 1: bump pulses for one cycle; position unchanged.
  - Next state: WON if the new position equals the goal, else READY. busy=0 on exit.
- Timing for RD_LATENCY=1: button in cycle N -> bram_rd_addr valid N+1 -> CHECK in N+2 -> new player_x/y, bump and busy=0 visible in N+3. Add one cycle per extra RD_LATENCY.
- WON:
  - at_goal=1; buttons ignored.
  - Only start or reset leaves this state.
- Outputs are registered. bram_rd_addr holds its last value outside FETCH/CHECK.
- Sharing the BRAM while the generator's write enable is high is the top level's responsibility; start must not be issued before the generator's done is high.

Test Plan:
- Level-1 maze loaded, start, btn_right in cycle N -> bram_rd_addr=8'h12 in N+1; player_x=2, player_y=1, move_count=1, busy=0 in N+3.
- From (1,1) press right 4 times -> (5,1), move_count=4; right again (cell (6,1) wall) -> bump high exactly one cycle, position (5,1), move_count stays 4.
- From (1,1) press up (row 0 all wall) -> bram_rd_addr=8'h01, bump pulse, position unchanged. Separately, instance with START_X=0 and left pressed -> bump in the next cycle, bram_rd_addr unchanged, busy never rises.
- btn_up and btn_right high in the same cycle at (1,1) -> only up processed (addr 8'h01). Button pulse during busy -> no second fetch.
- GOAL_X=2, GOAL_Y=1, right from (1,1) -> at_goal=1, state WON; further right presses change nothing; start -> (1,1), at_goal=0, move_count=0.
- reset low during FETCH -> next cycle all outputs at reset values, IDLE; buttons ignored until start. RD_LATENCY=3 build -> position update in N+5.
